// File: rtl/ahbl_pkg.sv
// Shared constants for the AHB-Lite runtime protocol checker:
// transfer encodings, violation bit indices and the error-response FSM states.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int N_CHECKS       = 4;
    localparam int VIOL_ADDR_HOLD = 0;
    localparam int VIOL_ALIGN     = 1;
    localparam int VIOL_RESP      = 2;
    localparam int VIOL_STALL     = 3;

    typedef enum logic {
        ERR_OK   = 1'b0,
        ERR_ERR1 = 1'b1
    } err_state_e;

endpackage

// File: rtl/ahbl_bus_checker_if.sv
// Bundle of N_PORTS AHB-Lite request/response signals, packed per port.
interface ahbl_bus_checker_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32
) ();

    logic [N_PORTS*W_ADDR-1:0] haddr;
    logic [N_PORTS-1:0]        hwrite;
    logic [2*N_PORTS-1:0]      htrans;
    logic [3*N_PORTS-1:0]      hsize;
    logic [N_PORTS-1:0]        hready;
    logic [N_PORTS-1:0]        hresp;

    modport master  (output haddr, hwrite, htrans, hsize, input hready, hresp);
    modport slave   (input haddr, hwrite, htrans, hsize, output hready, hresp);
    // The checker only snoops, so it sees every signal as an input.
    modport monitor (input haddr, hwrite, htrans, hsize, hready, hresp);

endinterface

// File: rtl/ahbl_port_checker.sv
// Protocol checks for a single AHB-Lite port: held-request compare, alignment,
// two-phase error response, bounded data-phase stall, and sticky flags.
module ahbl_port_checker
    import ahbl_pkg::*;
#(
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int MAX_BUS_STALL = -1,
    parameter int W_STALL       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W_ADDR-1:0]   haddr,
    input  logic                hwrite,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic                hready,
    input  logic                hresp,
    input  logic                clr,
    output logic [N_CHECKS-1:0] viol,
    output logic [N_CHECKS-1:0] viol_next,
    output logic                viol_set
);

    localparam int LOG2_BYTES = $clog2(W_DATA / 8);

    logic                hold_q, hold_d;
    logic [W_ADDR-1:0]   req_addr_q, req_addr_d;
    logic                req_write_q, req_write_d;
    logic [1:0]          req_trans_q, req_trans_d;
    logic [2:0]          req_size_q, req_size_d;
    logic                dph_q, dph_d;
    err_state_e          err_q, err_d;
    logic [N_CHECKS-1:0] viol_q, viol_d;
    logic [N_CHECKS-1:0] chk;
    logic [W_ADDR-1:0]   align_mask;
    logic                resp_viol;
    logic                stall_viol;

    always_comb begin
        hold_d      = htrans[1] & ~hready;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_trans_d = req_trans_q;
        req_size_d  = req_size_q;
        // The copy freezes while stalled so every stall cycle is compared
        // against the request as it was first presented.
        if (!hold_q) begin
            req_addr_d  = haddr;
            req_write_d = hwrite;
            req_trans_d = htrans;
            req_size_d  = hsize;
        end

        dph_d = hready ? htrans[1] : dph_q;

        err_d     = err_q;
        resp_viol = 1'b0;
        case (err_q)
            ERR_OK: begin
                if (hresp) begin
                    if (!hready && dph_q) err_d = ERR_ERR1;
                    else                  resp_viol = 1'b1;
                end
            end
            ERR_ERR1: begin
                if (!hresp) begin
                    resp_viol = 1'b1;
                    err_d     = ERR_OK;
                end else if (hready) begin
                    err_d = ERR_OK;
                end
            end
            default: err_d = ERR_OK;
        endcase

        align_mask = (W_ADDR'(1) << hsize) - W_ADDR'(1);

        chk                 = '0;
        chk[VIOL_ADDR_HOLD] = hold_q && ((htrans != req_trans_q) || (haddr != req_addr_q) ||
                                         (hwrite != req_write_q) || (hsize != req_size_q));
        chk[VIOL_ALIGN]     = htrans[1] && ((hsize > 3'(LOG2_BYTES)) || ((haddr & align_mask) != '0));
        chk[VIOL_RESP]      = resp_viol;
        chk[VIOL_STALL]     = stall_viol;

        viol_d = (viol_q & ~{N_CHECKS{clr}}) | chk;
    end

    generate
        if (MAX_BUS_STALL >= 0) begin : g_stall
            logic [W_STALL-1:0] stall_cnt_q, stall_cnt_d;

            always_comb begin
                stall_cnt_d = stall_cnt_q;
                if (hready)                              stall_cnt_d = '0;
                else if (dph_q && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 1'b1;
            end

            // Compare the updated count so the flag follows the offending wait state.
            assign stall_viol = int'(stall_cnt_d) > MAX_BUS_STALL;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stall_cnt_q <= '0;
                else        stall_cnt_q <= stall_cnt_d;
            end
        end else begin : g_no_stall
            assign stall_viol = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= 1'b0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_trans_q <= HTRANS_IDLE;
            req_size_q  <= '0;
            dph_q       <= 1'b0;
            err_q       <= ERR_OK;
            viol_q      <= '0;
        end else begin
            hold_q      <= hold_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_trans_q <= req_trans_d;
            req_size_q  <= req_size_d;
            dph_q       <= dph_d;
            err_q       <= err_d;
            viol_q      <= viol_d;
        end
    end

    assign viol      = viol_q;
    assign viol_next = viol_d;
    assign viol_set  = |chk;

endmodule

// File: rtl/ahbl_bus_checker.sv
// Multi-port AHB-Lite runtime checker: one port checker per bus port plus
// first-violation capture (lowest port wins) and an interrupt OR.
module ahbl_bus_checker
    import ahbl_pkg::*;
#(
    parameter int N_PORTS       = 2,
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int MAX_BUS_STALL = -1,
    parameter int W_STALL       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ahbl_bus_checker_if.monitor  bus,
    input  logic [N_PORTS-1:0]   clr,
    output logic [4*N_PORTS-1:0] viol,
    output logic                 viol_any,
    output logic                 first_valid,
    output logic [2:0]           first_port,
    output logic [3:0]           first_kind
);

    logic [4*N_PORTS-1:0] viol_next;
    logic [N_PORTS-1:0]   port_set;
    logic                 viol_any_q, viol_any_d;
    logic                 first_valid_q, first_valid_d;
    logic [2:0]           first_port_q, first_port_d;
    logic [3:0]           first_kind_q, first_kind_d;
    logic                 rec_clr;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        ahbl_port_checker #(
            .W_ADDR        (W_ADDR),
            .W_DATA        (W_DATA),
            .MAX_BUS_STALL (MAX_BUS_STALL),
            .W_STALL       (W_STALL)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .haddr     (bus.haddr[p*W_ADDR +: W_ADDR]),
            .hwrite    (bus.hwrite[p]),
            .htrans    (bus.htrans[2*p +: 2]),
            .hsize     (bus.hsize[3*p +: 3]),
            .hready    (bus.hready[p]),
            .hresp     (bus.hresp[p]),
            .clr       (clr[p]),
            .viol      (viol[4*p +: 4]),
            .viol_next (viol_next[4*p +: 4]),
            .viol_set  (port_set[p])
        );
    end

    always_comb begin
        first_valid_d = first_valid_q;
        first_port_d  = first_port_q;
        first_kind_d  = first_kind_q;
        viol_any_d    = |viol_next;

        rec_clr = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (first_port_q == 3'(p)) rec_clr = clr[p];
        end

        // A record being cleared may be replaced by a violation in the same cycle.
        if (!first_valid_q || rec_clr) begin
            first_valid_d = 1'b0;
            first_port_d  = '0;
            first_kind_d  = '0;
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (port_set[p]) begin
                    first_valid_d = 1'b1;
                    first_port_d  = 3'(p);
                    first_kind_d  = viol_next[4*p +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_any_q    <= 1'b0;
            first_valid_q <= 1'b0;
            first_port_q  <= '0;
            first_kind_q  <= '0;
        end else begin
            viol_any_q    <= viol_any_d;
            first_valid_q <= first_valid_d;
            first_port_q  <= first_port_d;
            first_kind_q  <= first_kind_d;
        end
    end

    assign viol_any    = viol_any_q;
    assign first_valid = first_valid_q;
    assign first_port  = first_port_q;
    assign first_kind  = first_kind_q;

endmodule

// File: tb/tb_ahbl_bus_checker.sv
// Directed bench for ahbl_bus_checker: two ports, 32-bit data, stall limit of 4.
module tb_ahbl_bus_checker;
    import ahbl_pkg::*;

    localparam int N_PORTS = 2;
    localparam int W_ADDR  = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_PORTS-1:0] clr = '0;
    logic [7:0]         viol;
    logic               viol_any;
    logic               first_valid;
    logic [2:0]         first_port;
    logic [3:0]         first_kind;

    int checks = 0;
    int passed = 0;

    ahbl_bus_checker_if #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR)) bus ();

    ahbl_bus_checker #(
        .N_PORTS       (N_PORTS),
        .W_ADDR        (W_ADDR),
        .W_DATA        (32),
        .MAX_BUS_STALL (4),
        .W_STALL       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .clr         (clr),
        .viol        (viol),
        .viol_any    (viol_any),
        .first_valid (first_valid),
        .first_port  (first_port),
        .first_kind  (first_kind)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [1:0] tr, input logic [31:0] a,
                            input logic [2:0] sz, input logic rdy, input logic rsp);
        bus.htrans[2*p +: 2]      = tr;
        bus.haddr[p*W_ADDR +: 32] = a;
        bus.hsize[3*p +: 3]       = sz;
        bus.hwrite[p]             = 1'b0;
        bus.hready[p]             = rdy;
        bus.hresp[p]              = rsp;
    endtask

    task automatic idle_all();
        for (int p = 0; p < N_PORTS; p++) set_port(p, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b0);
        clr = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL reset_viol: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (viol_any !== 1'b0) $display("[TB] FAIL reset_viol_any: got %b expected 0", viol_any); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL reset_first_valid: got %b expected 0", first_valid); else passed++;
        checks++; if (first_port !== 3'd0) $display("[TB] FAIL reset_first_port: got %0d expected 0", first_port); else passed++;
        checks++; if (first_kind !== 4'h0) $display("[TB] FAIL reset_first_kind: got %h expected 0", first_kind); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL reset_idle_viol: got %h expected %h", viol, 8'h00); else passed++;
    endtask

    task automatic test_addr_hold();
        do_reset();
        set_port(0, HTRANS_NONSEQ, 32'h100, 3'd2, 1'b0, 1'b0);
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL hold_stall1: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_NONSEQ, 32'h104, 3'd2, 1'b0, 1'b0);
        step();
        checks++; if (viol !== 8'h01) $display("[TB] FAIL hold_viol: got %h expected %h", viol, 8'h01); else passed++;
        checks++; if (viol_any !== 1'b1) $display("[TB] FAIL hold_viol_any: got %b expected 1", viol_any); else passed++;
        checks++; if (first_valid !== 1'b1) $display("[TB] FAIL hold_first_valid: got %b expected 1", first_valid); else passed++;
        checks++; if (first_port !== 3'd0) $display("[TB] FAIL hold_first_port: got %0d expected 0", first_port); else passed++;
        checks++; if (first_kind !== 4'b0001) $display("[TB] FAIL hold_first_kind: got %b expected 0001", first_kind); else passed++;
        step();
        set_port(0, HTRANS_NONSEQ, 32'h104, 3'd2, 1'b1, 1'b0);
        step();
        idle_all();
        step();
        step();
        clr = 2'b01;
        step();
        clr = 2'b00;
        checks++; if (viol !== 8'h00) $display("[TB] FAIL hold_clr_viol: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL hold_clr_first: got %b expected 0", first_valid); else passed++;
        checks++; if (viol_any !== 1'b0) $display("[TB] FAIL hold_clr_any: got %b expected 0", viol_any); else passed++;
    endtask

    task automatic test_align();
        do_reset();
        set_port(1, HTRANS_NONSEQ, 32'h102, 3'd1, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL align_half_ok: got %h expected %h", viol, 8'h00); else passed++;
        set_port(1, HTRANS_NONSEQ, 32'h102, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h20) $display("[TB] FAIL align_word: got %h expected %h", viol, 8'h20); else passed++;
        checks++; if (first_port !== 3'd1) $display("[TB] FAIL align_first_port: got %0d expected 1", first_port); else passed++;
        checks++; if (first_kind !== 4'b0010) $display("[TB] FAIL align_first_kind: got %b expected 0010", first_kind); else passed++;
        idle_all();
        clr = 2'b10;
        step();
        clr = 2'b00;
        checks++; if (viol !== 8'h00) $display("[TB] FAIL align_clr: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL align_clr_first: got %b expected 0", first_valid); else passed++;
        set_port(1, HTRANS_NONSEQ, 32'h100, 3'd3, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h20) $display("[TB] FAIL align_size3: got %h expected %h", viol, 8'h20); else passed++;
        idle_all();
        step();
    endtask

    task automatic test_resp();
        do_reset();
        set_port(0, HTRANS_NONSEQ, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b1);
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL resp_err1: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b1);
        step();
        idle_all();
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL resp_two_phase: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_NONSEQ, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b1);
        step();
        checks++; if (viol !== 8'h04) $display("[TB] FAIL resp_single: got %h expected %h", viol, 8'h04); else passed++;
        idle_all();
        clr = 2'b01;
        step();
        clr = 2'b00;
        checks++; if (viol !== 8'h00) $display("[TB] FAIL resp_clr: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_NONSEQ, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b1);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h04) $display("[TB] FAIL resp_err1_drop: got %h expected %h", viol, 8'h04); else passed++;
        idle_all();
        step();
    endtask

    task automatic test_stall();
        do_reset();
        set_port(0, HTRANS_NONSEQ, 32'h40, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b0);
        repeat (4) step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL stall_4_waits: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL stall_4_done: got %h expected %h", viol, 8'h00); else passed++;
        set_port(0, HTRANS_NONSEQ, 32'h40, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b0);
        repeat (4) step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL stall_before_5th: got %h expected %h", viol, 8'h00); else passed++;
        step();
        checks++; if (viol !== 8'h08) $display("[TB] FAIL stall_5_waits: got %h expected %h", viol, 8'h08); else passed++;
        idle_all();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_port(0, HTRANS_NONSEQ, 32'h101, 3'd2, 1'b1, 1'b0);
        set_port(1, HTRANS_NONSEQ, 32'h101, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h22) $display("[TB] FAIL both_viol: got %h expected %h", viol, 8'h22); else passed++;
        checks++; if (first_port !== 3'd0) $display("[TB] FAIL both_first_port: got %0d expected 0", first_port); else passed++;
        checks++; if (first_kind !== 4'b0010) $display("[TB] FAIL both_first_kind: got %b expected 0010", first_kind); else passed++;
        idle_all();
        step();
        clr = 2'b01;
        set_port(0, HTRANS_NONSEQ, 32'h101, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h22) $display("[TB] FAIL clr_set_wins: got %h expected %h", viol, 8'h22); else passed++;
        idle_all();
        clr = 2'b11;
        step();
        clr = 2'b00;
        checks++; if (viol !== 8'h00) $display("[TB] FAIL both_clr: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL both_clr_first: got %b expected 0", first_valid); else passed++;
    endtask

    task automatic test_reset_mid_err();
        do_reset();
        set_port(0, HTRANS_NONSEQ, 32'h0, 3'd2, 1'b1, 1'b0);
        set_port(1, HTRANS_NONSEQ, 32'h102, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b1);
        set_port(1, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if (viol !== 8'h20) $display("[TB] FAIL mid_err_pre: got %h expected %h", viol, 8'h20); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (viol !== 8'h00) $display("[TB] FAIL async_rst_viol: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (viol_any !== 1'b0) $display("[TB] FAIL async_rst_any: got %b expected 0", viol_any); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL async_rst_first: got %b expected 0", first_valid); else passed++;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        set_port(0, HTRANS_NONSEQ, 32'h0, 3'd2, 1'b1, 1'b0);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b0, 1'b1);
        step();
        set_port(0, HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b1);
        step();
        idle_all();
        step();
        checks++; if (viol !== 8'h00) $display("[TB] FAIL post_rst_err: got %h expected %h", viol, 8'h00); else passed++;
        checks++; if (first_valid !== 1'b0) $display("[TB] FAIL post_rst_first: got %b expected 0", first_valid); else passed++;
    endtask

    initial begin
        $display("[TB] starting ahbl_bus_checker bench");
        test_reset();
        test_addr_hold();
        test_align();
        test_resp();
        test_stall();
        test_back_to_back();
        test_reset_mid_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
